// File: rtl/spectrum_bin_streamer.sv
// Streams one FFT magnitude frame out of the spectrum RAM as (bin, amplitude) pairs.
// A 2-entry FIFO hides the 1-cycle RAM latency and absorbs downstream stalls.
module spectrum_bin_streamer #(
    parameter int NUM_BINS = 1024,
    parameter int ADDR_W   = 10,
    parameter int MAG_W    = 16,
    parameter int SHIFT    = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              frame_ready,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [MAG_W-1:0]  mem_data,
    output logic              bin_valid,
    input  logic              out_ready,
    output logic [10:0]       bin_index,
    output logic [9:0]        amplitude,
    output logic              first_bin,
    output logic              last_bin,
    output logic              busy,
    output logic              overrun
);
    localparam logic [10:0] LAST_IDX = 11'(NUM_BINS - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_e;

    state_e           state_q, state_d;
    logic [10:0]      rd_cnt_q, rd_cnt_d;
    logic             pending_q, pending_d;
    logic             overrun_q, overrun_d;

    logic             infl_q;
    logic [10:0]      infl_idx_q;
    logic             infl_first_q, infl_last_q;

    logic [1:0][10:0] f_idx_q;
    logic [1:0][9:0]  f_amp_q;
    logic [1:0]       f_first_q, f_last_q;
    logic             rd_ptr_q, wr_ptr_q;
    logic [1:0]       cnt_q;

    logic             pop, push, rd_en, drained;
    logic [1:0]       occ;
    logic [MAG_W-1:0] scaled;
    logic [9:0]       amp_sat;

    assign pop     = (cnt_q != 2'd0) && out_ready;
    assign push    = infl_q;
    // The slot freed by this cycle's pop is reusable: returning data lands on the same edge.
    assign occ     = cnt_q + {1'b0, infl_q} - {1'b0, pop};
    assign drained = (cnt_q == 2'd0) && !infl_q;
    assign scaled  = mem_data >> SHIFT;
    assign amp_sat = (scaled > MAG_W'(1023)) ? 10'd1023 : scaled[9:0];

    always_comb begin
        state_d   = state_q;
        rd_cnt_d  = rd_cnt_q;
        pending_d = pending_q;
        overrun_d = 1'b0;
        rd_en     = 1'b0;
        if (state_q != IDLE && frame_ready) begin
            if (!pending_q) pending_d = 1'b1;
            else            overrun_d = 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (frame_ready) begin
                    state_d  = SCAN;
                    rd_cnt_d = '0;
                end
            end
            SCAN: begin
                rd_en = (occ < 2'd2);
                if (rd_en) begin
                    if (rd_cnt_q == LAST_IDX) state_d  = DRAIN;
                    else                      rd_cnt_d = rd_cnt_q + 11'd1;
                end
            end
            DRAIN: begin
                if (drained) begin
                    // A request arriving on the hand-over cycle is kept, never dropped.
                    if (pending_q || frame_ready) begin
                        state_d   = SCAN;
                        rd_cnt_d  = '0;
                        pending_d = pending_q && frame_ready;
                        overrun_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            rd_cnt_q  <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_cnt_q  <= rd_cnt_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            infl_q       <= 1'b0;
            infl_idx_q   <= '0;
            infl_first_q <= 1'b0;
            infl_last_q  <= 1'b0;
            f_idx_q      <= '0;
            f_amp_q      <= '0;
            f_first_q    <= '0;
            f_last_q     <= '0;
            rd_ptr_q     <= 1'b0;
            wr_ptr_q     <= 1'b0;
            cnt_q        <= '0;
        end else begin
            infl_q <= rd_en;
            if (rd_en) begin
                infl_idx_q   <= rd_cnt_q;
                infl_first_q <= (rd_cnt_q == 11'd0);
                infl_last_q  <= (rd_cnt_q == LAST_IDX);
            end
            if (push) begin
                f_idx_q[wr_ptr_q]   <= infl_idx_q;
                f_amp_q[wr_ptr_q]   <= amp_sat;
                f_first_q[wr_ptr_q] <= infl_first_q;
                f_last_q[wr_ptr_q]  <= infl_last_q;
                wr_ptr_q            <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

    assign mem_rd    = rd_en;
    assign mem_addr  = ADDR_W'(rd_cnt_q);
    assign bin_valid = (cnt_q != 2'd0);
    assign bin_index = f_idx_q[rd_ptr_q];
    assign amplitude = f_amp_q[rd_ptr_q];
    assign first_bin = f_first_q[rd_ptr_q];
    assign last_bin  = f_last_q[rd_ptr_q];
    assign busy      = (state_q != IDLE);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_spectrum_bin_streamer.sv
// Bench for spectrum_bin_streamer: RAM model plus a bin-order reference model
// checking streaming, saturation, backpressure, frame queuing, reset and NUM_BINS=2.
module tb_spectrum_bin_streamer;
    localparam int NB = 1024;

    logic        clock = 1'b0;
    logic        reset, frame_ready, out_ready;
    logic        mem_rd, bin_valid, first_bin, last_bin, busy, overrun;
    logic [9:0]  mem_addr;
    logic [15:0] mem_data;
    logic [10:0] bin_index;
    logic [9:0]  amplitude;

    logic        s_frame_ready, s_out_ready;
    logic        s_mem_rd, s_bin_valid, s_first, s_last, s_busy, s_overrun;
    logic [0:0]  s_mem_addr;
    logic [15:0] s_mem_data;
    logic [10:0] s_bin_index;
    logic [9:0]  s_amplitude;

    logic [15:0] ram  [NB];
    logic [15:0] ram2 [2];

    int errors = 0, checks = 0, cyc = 0;
    int reads = 0, xfers = 0, frames = 0, exp_idx = 0, exp_addr = 0, ov_cnt = 0;
    int gap = -1, last_cyc = 0;
    logic have_last = 1'b0, stall_prev = 1'b0;
    logic [10:0] h_idx;
    logic [9:0]  h_amp;
    logic        h_first, h_last;
    int sat_amp [3];

    spectrum_bin_streamer #(.NUM_BINS(NB), .ADDR_W(10), .MAG_W(16), .SHIFT(6)) dut (
        .clock(clock), .reset(reset), .frame_ready(frame_ready),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
        .bin_valid(bin_valid), .out_ready(out_ready), .bin_index(bin_index),
        .amplitude(amplitude), .first_bin(first_bin), .last_bin(last_bin),
        .busy(busy), .overrun(overrun)
    );

    spectrum_bin_streamer #(.NUM_BINS(2), .ADDR_W(1), .MAG_W(16), .SHIFT(6)) dut2 (
        .clock(clock), .reset(reset), .frame_ready(s_frame_ready),
        .mem_rd(s_mem_rd), .mem_addr(s_mem_addr), .mem_data(s_mem_data),
        .bin_valid(s_bin_valid), .out_ready(s_out_ready), .bin_index(s_bin_index),
        .amplitude(s_amplitude), .first_bin(s_first), .last_bin(s_last),
        .busy(s_busy), .overrun(s_overrun)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        mem_data   <= ram[mem_addr];
        s_mem_data <= ram2[s_mem_addr];
    end

    function automatic int ref_amp(input int v);
        int s;
        s = v / 64;
        return (s > 1023) ? 1023 : s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        reads = 0; xfers = 0; exp_idx = 0; exp_addr = 0;
        stall_prev = 1'b0; have_last = 1'b0;
    endtask

    task automatic check_reset_vals(input string p);
        chk({p, "_mem_rd"}, mem_rd, 0);
        chk({p, "_mem_addr"}, mem_addr, 0);
        chk({p, "_bin_valid"}, bin_valid, 0);
        chk({p, "_bin_index"}, bin_index, 0);
        chk({p, "_amplitude"}, amplitude, 0);
        chk({p, "_first_bin"}, first_bin, 0);
        chk({p, "_last_bin"}, last_bin, 0);
        chk({p, "_busy"}, busy, 0);
        chk({p, "_overrun"}, overrun, 0);
    endtask

    // One clock of the main DUT: drive inputs, then check against the bin-order model.
    task automatic step(input logic rdy, input logic fr);
        @(negedge clock);
        out_ready   = rdy;
        frame_ready = fr;
        #1;
        cyc++;
        if (overrun) ov_cnt++;
        if (stall_prev) begin
            chk("hold_valid", bin_valid, 1);
            chk("hold_index", bin_index, h_idx);
            chk("hold_amp", amplitude, h_amp);
            chk("hold_first", first_bin, h_first);
            chk("hold_last", last_bin, h_last);
        end
        chk("outstanding_le2", (reads - xfers) <= 2, 1);
        if (mem_rd) begin
            chk("rd_addr", mem_addr, exp_addr);
            exp_addr++;
            reads++;
        end
        if (bin_valid && out_ready) begin
            chk("bin_index", bin_index, exp_idx);
            chk("amplitude", amplitude, ref_amp(int'(ram[exp_idx])));
            chk("first_bin", first_bin, exp_idx == 0);
            chk("last_bin", last_bin, exp_idx == NB - 1);
            if (exp_idx >= 5 && exp_idx <= 7) sat_amp[exp_idx - 5] = int'(amplitude);
            if (exp_idx == 0 && have_last) gap = cyc - last_cyc;
            xfers++;
            exp_idx++;
            if (exp_idx == NB) begin
                exp_idx   = 0;
                exp_addr  = 0;
                reads     = 0;
                xfers     = 0;
                frames++;
                last_cyc  = cyc;
                have_last = 1'b1;
            end
        end
        stall_prev = bin_valid && !out_ready;
        h_idx = bin_index; h_amp = amplitude; h_first = first_bin; h_last = last_bin;
    endtask

    task automatic run_frames(input int n, input int pct, input int budget);
        int target, i;
        target = frames + n;
        i = 0;
        while (frames < target && i < budget) begin
            step($urandom_range(0, 99) < pct, 1'b0);
            i++;
        end
        chk("frames_done", frames, target);
    endtask

    initial begin
        int c0, f0, ov0, n, nrd;
        logic [10:0] p_idx [4];
        logic [9:0]  p_amp [4];
        logic        p_first [4], p_last [4];

        for (int i = 0; i < NB; i++) ram[i] = 16'(i << 6);
        ram2[0] = 16'h1234;
        ram2[1] = 16'hFFFF;
        reset = 1'b1; frame_ready = 1'b0; out_ready = 1'b0;
        s_frame_ready = 1'b0; s_out_ready = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        check_reset_vals("rst");
        chk("rst_s_valid", s_bin_valid, 0);
        @(negedge clock);
        reset = 1'b0;

        // Straight stream, out_ready high: latency and 1 bin/cycle.
        ov0 = ov_cnt;
        step(1'b1, 1'b1);
        chk("lat_busy_c0", busy, 0);
        step(1'b1, 1'b0);
        chk("lat_mem_rd_c1", mem_rd, 1);
        chk("lat_busy_c1", busy, 1);
        step(1'b1, 1'b0);
        chk("lat_valid_c2", bin_valid, 0);
        step(1'b1, 1'b0);
        c0 = cyc;
        chk("lat_valid_c3", bin_valid, 1);
        chk("lat_first_c3", first_bin, 1);
        run_frames(1, 100, 1100);
        chk("throughput", cyc - c0, NB - 1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        chk("busy_drop", busy, 0);
        chk("idle_no_overrun", ov_cnt, ov0);

        // Random contents with saturation corners under 30% backpressure.
        for (int i = 0; i < NB; i++) ram[i] = 16'($urandom_range(0, 65535));
        ram[5] = 16'hFFFF;
        ram[6] = 16'd65472;
        ram[7] = 16'd63;
        step(1'b0, 1'b1);
        run_frames(1, 30, 8000);
        chk("sat_ffff", sat_amp[0], 1023);
        chk("sat_65472", sat_amp[1], 1023);
        chk("sat_63", sat_amp[2], 0);
        repeat (3) step(1'b1, 1'b0);

        // Two queued frames plus a third request that must be dropped.
        f0 = frames; ov0 = ov_cnt; gap = -1; have_last = 1'b0;
        step(1'b1, 1'b1);
        repeat (9) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        repeat (9) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        run_frames(2, 100, 3000);
        chk("frame2_back_to_back", (gap >= 1) && (gap <= 5), 1);
        repeat (60) step(1'b1, 1'b0);
        chk("no_third_frame", frames, f0 + 2);
        chk("overrun_pulses", ov_cnt - ov0, 1);
        chk("idle_after_two", busy, 0);

        // Reset while stalled on bin 300, then a fresh frame.
        begin
            int i;
            step(1'b1, 1'b1);
            i = 0;
            while (exp_idx < 300 && i < 2000) begin
                step(1'b1, 1'b0);
                i++;
            end
        end
        chk("reach_bin300", exp_idx, 300);
        repeat (3) step(1'b0, 1'b0);
        chk("stall_head300", bin_index, 300);
        @(negedge clock);
        reset = 1'b1; out_ready = 1'b0;
        @(negedge clock);
        #1;
        check_reset_vals("midrst");
        reset = 1'b0;
        model_reset();
        repeat (10) step(1'b1, 1'b0);
        chk("post_rst_no_xfer", xfers, 0);
        chk("post_rst_no_read", reads, 0);
        for (int i = 0; i < NB; i++) ram[i] = 16'($urandom_range(0, 65535));
        step(1'b1, 1'b1);
        run_frames(1, 100, 1100);

        // NUM_BINS = 2 instance.
        for (int f = 0; f < 2; f++) begin
            n = 0; nrd = 0;
            for (int i = 0; i < 30; i++) begin
                @(negedge clock);
                s_frame_ready = (i == 0);
                s_out_ready   = 1'($urandom_range(0, 1));
                #1;
                if (s_mem_rd) nrd++;
                if (s_bin_valid && s_out_ready) begin
                    if (n < 4) begin
                        p_idx[n] = s_bin_index; p_amp[n] = s_amplitude;
                        p_first[n] = s_first; p_last[n] = s_last;
                    end
                    n++;
                end
            end
            chk("nb2_pairs", n, 2);
            chk("nb2_reads", nrd, 2);
            chk("nb2_idx0", p_idx[0], 0);
            chk("nb2_first0", p_first[0], 1);
            chk("nb2_last0", p_last[0], 0);
            chk("nb2_amp0", p_amp[0], ref_amp(int'(ram2[0])));
            chk("nb2_idx1", p_idx[1], 1);
            chk("nb2_first1", p_first[1], 0);
            chk("nb2_last1", p_last[1], 1);
            chk("nb2_amp1", p_amp[1], ref_amp(int'(ram2[1])));
            chk("nb2_idle", s_busy, 0);
            chk("nb2_overrun", s_overrun, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/spectrum_bin_streamer.md
Name: spectrum_bin_streamer

Overview:
Reads one completed FFT magnitude frame out of the spectrum RAM and streams it bin by bin as (bin_index, amplitude) pairs with a valid/ready handshake. It is the producer for the peak-search and display logic, which consume hcount/amplitude-style bin streams.
It hides the RAM's 1-cycle read latency, scales and saturates raw magnitudes to 10 bits, and tolerates downstream stalls without losing or duplicating bins.

Parameters:
NUM_BINS, 1024, bins per frame, streamed as indices 0..NUM_BINS-1; legal range 2..2048.
ADDR_W, 10, spectrum RAM address width; 2^ADDR_W >= NUM_BINS.
MAG_W, 16, raw magnitude width from RAM.
SHIFT, 6, right shift applied to the raw magnitude before saturation.

Ports:
clock  in  1  system clock; all logic on the rising edge.
reset  in  1  synchronous, active-high reset.
frame_ready  in  1  1-cycle pulse: a new complete frame is in RAM.
mem_rd  out  1  RAM read strobe.
mem_addr  out  ADDR_W  RAM read address; meaningful only when mem_rd=1.
mem_data  in  MAG_W  RAM read data, valid exactly 1 cycle after mem_rd.
bin_valid  out  1  output pair is valid.
out_ready  in  1  downstream accepts the pair this cycle.
bin_index  out  11  bin number of the current output pair.
amplitude  out  10  scaled, saturated magnitude.
first_bin  out  1  asserted with bin 0 of a frame.
last_bin  out  1  asserted with bin NUM_BINS-1.
busy  out  1  a frame is in progress (state != IDLE).
overrun  out  1  1-cycle pulse when a frame_ready is dropped.

Behaviour:
- Reset values: mem_rd=0, mem_addr=0, bin_valid=0, bin_index=0, amplitude=0, first_bin=0, last_bin=0, busy=0, overrun=0. Reset also clears the FSM, read counter, in-flight flag, output buffer and pending flag.
- Reset asserted mid-frame aborts the frame immediately. No further bins are emitted, and any in-flight RAM data is discarded.
- Handshake: a pair transfers when bin_valid && out_ready. While bin_valid=1 and out_ready=0, the outputs bin_index, amplitude, first_bin and last_bin hold stable. bin_valid never drops without a transfer unless reset is asserted.
- Buffering: a 2-entry FIFO holds (index, amplitude, first, last); its head drives the outputs.
  - A read may issue only if (occupied entries + in-flight reads) < 2. This guarantees that returning RAM data always has a free slot.
- Throughput: with out_ready held high, the stream runs at 1 bin/cycle.
- Latency: the first mem_rd is asserted the cycle after frame_ready is sampled in IDLE. bin_valid for bin 0 is asserted 2 cycles after that mem_rd.
- Arithmetic: scaled = mem_data >> SHIFT; amplitude = (scaled > 1023) ? 1023 : scaled[9:0].
- bin_index is the zero-extended read address, captured alongside the read request.
- FSM states:
  - IDLE: on frame_ready, go to SCAN with the read counter set to 0.
  - SCAN: issue reads at addresses 0..NUM_BINS-1, subject to the credit rule. After issuing NUM_BINS-1, go to DRAIN.
  - DRAIN: wait until there are no in-flight reads and the FIFO is empty (last_bin transferred). Then go to SCAN (counter=0) if the pending flag is set, clearing it; otherwise go to IDLE.
- frame_ready while busy:
  - If the pending flag is clear, set it.
  - If the pending flag is already set, pulse overrun and drop the request.
  - A frame_ready in the same cycle as the DRAIN→IDLE/SCAN transition counts as a pending request and is not dropped.
  - A frame_ready in IDLE never raises overrun.
- Frames never interleave: bin 0 of frame N+1 is emitted only after last_bin of frame N has been accepted.
- mem_addr never exceeds NUM_BINS-1, and no address is read twice within a frame.
- Extended out_ready low stalls the reads; no data is lost and no read is duplicated.

Test Plan:
- RAM[i]=i<<6, NUM_BINS=1024, out_ready=1, single frame_ready pulse → bins 0..1023 appear on consecutive cycles with amplitude=i mod 1024 (i<1024) and bin_index=i. first_bin is asserted with bin 0 only, last_bin with bin 1023 only. bin 0 is valid 3 cycles after the frame_ready pulse; busy drops after the last transfer.
- Saturation: RAM[5]=16'hFFFF and RAM[6]=16'd65472 → amplitude 1023 for both; RAM[7]=16'd63 → amplitude 0.
- Backpressure: random out_ready at 30% duty → the accepted sequence is exactly indices 0..NUM_BINS-1 with correct amplitudes, outputs stay stable during stalls, and at most 2 reads are outstanding or buffered at any time.
- Two frame_ready pulses 10 cycles apart, then a third pulse → frame 2 starts immediately after frame 1's last_bin transfer; the third pulse produces a 1-cycle overrun and no third frame.
- Reset asserted at bin 300 with out_ready=0 → next cycle all outputs are at reset values. A following frame_ready streams a fresh frame from bin 0 with no stale data.
- NUM_BINS=2 → exactly two pairs per frame; the first carries first_bin=1 and the second carries last_bin=1.
